// File: rtl/serializer_if.sv
// Handshake bundle for the serializer: parallel message in, serial words out.
// Latency: none, wires only.
// Backpressure: recv_rdy/send_rdy carry the stall in each direction.
interface serializer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);
  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg;
  logic                           recv_val;
  logic                           recv_rdy;
  logic [BIT_WIDTH-1:0]           send_msg;
  logic                           send_val;
  logic                           send_rdy;

  // Environment side: produces messages, consumes words
  modport master (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val
  );

  // Serializer side
  modport slave (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val
  );
endinterface

// File: rtl/serializer.sv
// Serializer: splits one BIT_WIDTH*N_SAMPLES message into N_SAMPLES words, word 0 (LSBs) first.
// Latency: first word valid the cycle after the input handshake; one message per N_SAMPLES+1 cycles.
// Backpressure: send_rdy low freezes the current word; recv_rdy stays low until the last word leaves.
module serializer #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input logic         clk,
  input logic         reset,
  serializer_if.slave bus
);
  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int MSG_W = BIT_WIDTH * N_SAMPLES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [MSG_W-1:0] msg_q, msg_nxt;

  // State, word counter and captured message; reset drops any half-sent message
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      msg_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      msg_q <= msg_nxt;
    end
  end

  // Capture a message in IDLE, then step through its words on each output handshake
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    msg_nxt   = msg_q;
    case (state)
      IDLE: begin
        // recv_rdy is high throughout IDLE, so recv_val alone completes the handshake
        if (bus.recv_val) begin
          state_nxt = SEND;
          count_nxt = '0;
          msg_nxt   = bus.recv_msg;
        end
      end
      SEND: begin
        // recv_val/recv_msg are deliberately ignored here
        if (bus.send_rdy) begin
          if (count == LAST) begin
            state_nxt = IDLE;
            count_nxt = '0;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so no input reaches them combinationally
  assign bus.recv_rdy = (state == IDLE);
  assign bus.send_val = (state == SEND);
  assign bus.send_msg = (state == SEND) ? msg_q[int'(count)*BIT_WIDTH +: BIT_WIDTH] : '0;
endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, meaning the width of one output word.
REQ-002 SHALL have parameter N_SAMPLES, default 8, meaning the number of output words per input message (legal range 1 to 256).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port recv_msg, input, BIT_WIDTH*N_SAMPLES bits: parallel input message.
REQ-006 SHALL have port recv_val, input, 1 bit: upstream asserts that recv_msg is valid.
REQ-007 SHALL have port recv_rdy, output, 1 bit: block can accept a message.
REQ-008 SHALL have port send_msg, output, BIT_WIDTH bits: current serial output word.
REQ-009 SHALL have port send_val, output, 1 bit: send_msg is valid.
REQ-010 SHALL have port send_rdy, input, 1 bit: downstream can accept a word.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and SEND.
REQ-012 SHALL define a handshake on either interface as val and rdy both high at a rising clk edge.
REQ-013 SHALL drive recv_rdy=1 and send_val=0 in IDLE, and recv_rdy=0 and send_val=1 in SEND.
REQ-014 SHALL decode recv_rdy and send_val from state only, with no combinational path from any input to them.
REQ-015 SHALL, on an input handshake in IDLE, capture recv_msg into an internal BIT_WIDTH*N_SAMPLES register, clear the word counter to 0, and enter SEND on the same edge.
REQ-016 SHALL drive send_msg in SEND with word[count] of the captured register, where word k is bits [k*BIT_WIDTH +: BIT_WIDTH] (word 0 is the LSBs and is sent first).
REQ-017 SHALL drive send_msg to all zeros in IDLE.
REQ-018 SHALL size the word counter to max(1, clog2(N_SAMPLES)) bits.
REQ-019 SHALL, on an output handshake in SEND with count < N_SAMPLES-1, increment count by 1 and stay in SEND.
REQ-020 SHALL, on an output handshake in SEND with count == N_SAMPLES-1, clear count to 0 and return to IDLE.
REQ-021 SHALL hold count, the captured register, and state in SEND while send_rdy=0 (backpressure), keeping send_msg stable.
REQ-022 SHALL ignore recv_val and recv_msg while in SEND; the captured register is not overwritten until the next IDLE handshake.
REQ-023 SHALL, for N_SAMPLES=1, send exactly one word per message and return to IDLE after that word's handshake.
REQ-024 SHALL present the first word one cycle after the input handshake; throughput is one message per N_SAMPLES+1 cycles when send_rdy is held high.
REQ-025 SHALL keep the count from ever exceeding N_SAMPLES-1 (no wrap-around past the last word).

Reset
REQ-026 SHALL, while reset=1 and independent of clk, force state=IDLE, count=0, captured register=0, recv_rdy=1, send_val=0, and send_msg=0.
REQ-027 SHALL discard any partially sent message on reset asserted mid-SEND; no remaining words are emitted after reset is released.
REQ-028 SHALL accept a new message on the first rising edge after reset deasserts if recv_val=1.

Verification (BIT_WIDTH=8, N_SAMPLES=4 unless stated)
REQ-029 SHALL verify the basic stream: recv_msg=32'hDDCCBBAA with one-cycle recv_val and send_rdy=1 -> send_msg is AA, BB, CC, DD on 4 consecutive cycles with send_val=1, then recv_rdy=1 on the following cycle.
REQ-030 SHALL verify backpressure: as REQ-029 with send_rdy=0 for 3 cycles while BB is shown -> send_msg holds BB with send_val=1 for those cycles; CC and DD follow once send_rdy=1; no words are lost or duplicated.
REQ-031 SHALL verify that input is ignored in SEND: a second recv_val with 32'h44332211 while sending 32'hDDCCBBAA -> recv_rdy=0 and the output remains AA..DD; 11..44 appear only if recv_val is still high once back in IDLE.
REQ-032 SHALL verify reset mid-message: assert reset asynchronously after BB is accepted -> send_val=0, send_msg=0, and recv_rdy=1 immediately; no CC or DD is emitted afterward.
REQ-033 SHALL verify back-to-back messages: recv_val held high with 32'h04030201 then 32'h08070605 and send_rdy=1 -> output 01,02,03,04 then 05..08, with one IDLE cycle between the two messages.
REQ-034 SHALL verify N_SAMPLES=1 with BIT_WIDTH=8: input 8'h5A -> one word 5A with send_val=1 for one cycle, then IDLE.
